// File: rtl/vertex_fetch_if.sv
// Signal bundle between the scene/control + vertex BRAM side (master) and the
// vertex_fetch sequencer (slave).
interface vertex_fetch_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                        start_in;
  logic [3:0][3:0][31:0]       mat_in;
  logic [ADDR_WIDTH-1:0]       base_addr_in;
  logic [ADDR_WIDTH-1:0]       count_in;
  logic                        rd_en_out;
  logic [ADDR_WIDTH-1:0]       addr_out;
  logic [2:0][31:0]            rdata_in;
  logic                        col_set_out;
  logic [3:0][31:0]            col_out;
  logic                        valid_out;
  logic [2:0][31:0]            vertex_out;
  logic                        busy_out;
  logic                        done_out;

  modport master (
    output start_in, mat_in, base_addr_in, count_in, rdata_in,
    input  rd_en_out, addr_out, col_set_out, col_out, valid_out, vertex_out,
           busy_out, done_out
  );

  modport slave (
    input  start_in, mat_in, base_addr_in, count_in, rdata_in,
    output rd_en_out, addr_out, col_set_out, col_out, valid_out, vertex_out,
           busy_out, done_out
  );
endinterface

// File: rtl/vertex_fetch.sv
// Frame sequencer for the vertex shader: streams a latched 4x4 transform as
// four column writes, then fetches count vertices from BRAM one per cycle.
module vertex_fetch #(
  parameter int ADDR_WIDTH   = 10,
  parameter int BRAM_LATENCY = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  vertex_fetch_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [BRAM_LATENCY-1:0] VLD_LAST = BRAM_LATENCY'(1) << (BRAM_LATENCY - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_cidx;
  logic [ADDR_WIDTH-1:0]   r_left;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [3:0][3:0][31:0]   r_mat;
  logic [3:0][31:0]        r_col;
  logic [BRAM_LATENCY-1:0] r_vld_p;
  logic [2:0][31:0]        r_vertex;

  logic                    w_start;
  logic                    w_rd_en;
  logic                    w_vld;
  logic                    w_last_col;
  logic                    w_pipe_drained;

  assign w_start    = (r_state == S_IDLE) && bus.start_in;
  assign w_rd_en    = (r_state == S_FETCH);
  assign w_vld      = r_vld_p[BRAM_LATENCY-1];
  assign w_last_col = (r_cidx == 2'd3);
  // Only the read currently leaving the pipe may remain; nothing younger in flight.
  assign w_pipe_drained = ((r_vld_p & ~VLD_LAST) == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_in) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_last_col) w_state_nxt = (r_left != '0) ? S_FETCH : S_DONE;
      S_FETCH: if (r_left == ADDR_WIDTH'(1)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pipe_drained) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_cidx   <= '0;
      r_left   <= '0;
      r_addr   <= '0;
      r_col    <= '0;
      r_vld_p  <= '0;
      r_vertex <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vld_p <= (r_vld_p << 1) | BRAM_LATENCY'(w_rd_en);
      if (w_vld) r_vertex <= bus.rdata_in;
      if (w_start) begin
        r_col  <= bus.mat_in[0];
        r_cidx <= '0;
        r_addr <= bus.base_addr_in;
        r_left <= bus.count_in;
      end else if (r_state == S_LOAD) begin
        r_cidx <= r_cidx + 2'd1;
        if (!w_last_col) r_col <= r_mat[r_cidx + 2'd1];
      end else if (w_rd_en) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_left <= r_left - ADDR_WIDTH'(1);
      end
    end
  end

  // Matrix is pure data: captured on an accepted start, never cleared.
  always_ff @(posedge clk_in) begin
    if (w_start) r_mat <= bus.mat_in;
  end

  // BRAM data arrives in the same cycle as its valid bit; the register holds it afterwards.
  assign bus.vertex_out  = w_vld ? bus.rdata_in : r_vertex;
  assign bus.valid_out   = w_vld;
  assign bus.rd_en_out   = w_rd_en;
  assign bus.addr_out    = r_addr;
  assign bus.col_set_out = (r_state == S_LOAD);
  assign bus.col_out     = r_col;
  assign bus.busy_out    = (r_state != S_IDLE);
  assign bus.done_out    = (r_state == S_DONE);

endmodule

// File: tb/tb_vertex_fetch.sv
// Scoreboard bench for vertex_fetch: three instances (BRAM latency 1, 2, 4)
// driven by randomized and directed frames, checked against a cycle-level frame model.
module tb_vertex_fetch;
  localparam int AW = 10;
  localparam int NI = 3;
  localparam int K_COL = 0, K_RD = 1, K_VLD = 2, K_DONE = 3;

  typedef struct {
    int           inst;
    int           kind;
    int           cyc;
    logic [127:0] d;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                  rst_a   [NI];
  logic                  start_a [NI];
  logic [3:0][3:0][31:0] mat_a   [NI];
  logic [AW-1:0]         base_a  [NI];
  logic [AW-1:0]         cnt_a   [NI];
  logic [95:0]           rdata_a [NI];
  logic                  rd_en_a [NI];
  logic [AW-1:0]         addr_a  [NI];
  logic                  colset_a[NI];
  logic [127:0]          col_a   [NI];
  logic                  vld_a   [NI];
  logic [95:0]           vtx_a   [NI];
  logic                  busy_a  [NI];
  logic                  done_a  [NI];

  logic [95:0] mem [NI][1024];
  ev_t         sb[$];
  int          busy_lo [NI];
  int          busy_hi [NI];
  bit          mon_en  [NI];
  int          total = 0;
  int          bad   = 0;

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    vertex_fetch_if #(.ADDR_WIDTH(AW)) vif ();
    logic [AW-1:0] bp [4];

    assign vif.start_in     = start_a[g];
    assign vif.mat_in       = mat_a[g];
    assign vif.base_addr_in = base_a[g];
    assign vif.count_in     = cnt_a[g];
    assign vif.rdata_in     = rdata_a[g];
    assign rd_en_a[g]  = vif.rd_en_out;
    assign addr_a[g]   = vif.addr_out;
    assign colset_a[g] = vif.col_set_out;
    assign col_a[g]    = vif.col_out;
    assign vld_a[g]    = vif.valid_out;
    assign vtx_a[g]    = vif.vertex_out;
    assign busy_a[g]   = vif.busy_out;
    assign done_a[g]   = vif.done_out;

    vertex_fetch #(.ADDR_WIDTH(AW), .BRAM_LATENCY(L)) u_dut (
      .clk_in (clk),
      .rst_in (rst_a[g]),
      .bus    (vif.slave)
    );

    // BRAM model: data for the address presented in cycle R is on rdata in cycle R+L.
    always @(posedge clk) begin
      bp[0] <= addr_a[g];
      for (int k = 1; k < 4; k++) bp[k] <= bp[k-1];
    end
    assign rdata_a[g] = mem[g][bp[L-1]];
  end

  function automatic string kname(int k);
    case (k)
      K_COL:   return "col";
      K_RD:    return "read";
      K_VLD:   return "vertex";
      default: return "done";
    endcase
  endfunction

  task automatic push(int i, int kind, int c, logic [127:0] d);
    ev_t e;
    e.inst = i; e.kind = kind; e.cyc = c; e.d = d;
    sb.push_back(e);
  endtask

  // Reference frame: start seen in cycle s; columns s+1..s+4, reads from s+5,
  // each vertex L cycles after its read, done one cycle after the last vertex.
  task automatic push_frame(int i, int s, logic [3:0][3:0][31:0] m, logic [AW-1:0] base, int n);
    int L = lat_of(i);
    int dn;
    logic [AW-1:0] a;
    for (int k = 0; k < 4; k++) push(i, K_COL, s + 1 + k, m[k]);
    for (int j = 0; j < n; j++) begin
      a = AW'((int'(base) + j) % 1024);
      push(i, K_RD, s + 5 + j, 128'(a));
      push(i, K_VLD, s + 5 + j + L, 128'(mem[i][a]));
    end
    dn = (n == 0) ? s + 5 : s + 5 + n + L;
    push(i, K_DONE, dn, '0);
    busy_lo[i] = s + 1;
    busy_hi[i] = dn;
  endtask

  // A reset sampled at the end of cycle r cancels every event after r.
  task automatic apply_reset(int i, int r);
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].inst == i && sb[k].cyc > r) sb.delete(k);
    if (busy_hi[i] > r) busy_hi[i] = r;
  endtask

  task automatic check_kind(int i, int kind, logic flag, logic [127:0] act, int c);
    int idx = -1;
    if (flag !== 1'b1) return;
    for (int k = 0; k < sb.size(); k++)
      if (sb[k].inst == i && sb[k].kind == kind) begin idx = k; break; end
    total++;
    if (idx < 0) begin
      bad++;
      $display("FAIL unexpected_%s inst=%0d cyc=%0d got=%h required=none", kname(kind), i, c, act);
    end else begin
      if (sb[idx].cyc != c || sb[idx].d !== act) begin
        bad++;
        $display("FAIL %s inst=%0d got=%h@%0d required=%h@%0d",
                 kname(kind), i, act, c, sb[idx].d, sb[idx].cyc);
      end
      sb.delete(idx);
    end
  endtask

  task automatic monitor_inst(int i);
    int  c = cyc;
    bit  exp_busy;
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].inst == i && sb[k].cyc < c) begin
        total++; bad++;
        $display("FAIL missing_%s inst=%0d got=none required_cyc=%0d data=%h",
                 kname(sb[k].kind), i, sb[k].cyc, sb[k].d);
        sb.delete(k);
      end
    check_kind(i, K_COL,  colset_a[i], col_a[i], c);
    check_kind(i, K_RD,   rd_en_a[i],  128'(addr_a[i]), c);
    check_kind(i, K_VLD,  vld_a[i],    128'(vtx_a[i]), c);
    check_kind(i, K_DONE, done_a[i],   '0, c);
    exp_busy = (c >= busy_lo[i]) && (c <= busy_hi[i]);
    total++;
    if (busy_a[i] !== exp_busy) begin
      bad++;
      $display("FAIL busy inst=%0d cyc=%0d got=%b required=%b", i, c, busy_a[i], exp_busy);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++)
      if (mon_en[i]) monitor_inst(i);
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(int i, string name);
    logic [255:0] all;
    all = {rd_en_a[i], addr_a[i], colset_a[i], col_a[i], vld_a[i], vtx_a[i], busy_a[i], done_a[i]};
    total++;
    if (all !== '0) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h required=0", name, i, all);
    end
  endtask

  task automatic rand_mat(output logic [3:0][3:0][31:0] m);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[c][r] = $urandom();
  endtask

  task automatic do_start(int i, logic [3:0][3:0][31:0] m, logic [AW-1:0] base, int n);
    logic [3:0][3:0][31:0] junk;
    start_a[i] = 1'b1;
    mat_a[i]   = m;
    base_a[i]  = base;
    cnt_a[i]   = AW'(n);
    if (cyc > busy_hi[i]) push_frame(i, cyc, m, base, n);
    step(1);
    rand_mat(junk);
    start_a[i] = 1'b0;
    mat_a[i]   = junk;
    base_a[i]  = AW'($urandom());
    cnt_a[i]   = AW'($urandom());
  endtask

  task automatic wait_idle(int i);
    if (busy_hi[i] >= cyc) step(busy_hi[i] - cyc + 1);
  endtask

  task automatic run_seq(int i);
    logic [3:0][3:0][31:0] m1, m2;
    int left;
    m1[0] = {32'h40C00000, 32'h3F800000, 32'h40000000, 32'h41100000};
    m1[1] = {32'h40400000, 32'h00000000, 32'h41100000, 32'h40C00000};
    m1[2] = {32'h3F800000, 32'h40400000, 32'h3F800000, 32'h40A00000};
    m1[3] = {32'h3F800000, 32'h40A00000, 32'h40E00000, 32'h00000000};
    rand_mat(m2);
    rst_a[i] = 1'b1; start_a[i] = 1'b0; mat_a[i] = '0; base_a[i] = '0; cnt_a[i] = '0;
    busy_lo[i] = 0; busy_hi[i] = -1;
    step(3);
    rst_a[i] = 1'b0;
    check_zero(i, "reset_state");
    mon_en[i] = 1'b1;
    step(2);
    // count 0: columns only, then done
    do_start(i, m1, AW'(0), 0);
    wait_idle(i); step(2);
    // single vertex at address 5
    mem[i][5] = {32'h40800000, 32'h3F800000, 32'h40A00000};
    do_start(i, m1, AW'(5), 1);
    wait_idle(i); step(1);
    // burst across the address wrap
    do_start(i, m1, AW'(1022), 4);
    wait_idle(i); step(1);
    // start mid-FETCH ignored, back-to-back start after done accepted
    do_start(i, m1, AW'(100), 6);
    step(5);
    do_start(i, m2, AW'(300), 9);
    wait_idle(i);
    do_start(i, m2, AW'(1020), 3);
    wait_idle(i); step(2);
    // reset one cycle after the second read
    do_start(i, m1, AW'(200), 8);
    step(6);
    rst_a[i] = 1'b1;
    apply_reset(i, cyc);
    step(1);
    rst_a[i] = 1'b0;
    check_zero(i, "reset_abort");
    step(12);
    // randomized frames, some back-to-back
    for (int r = 0; r < 6; r++) begin
      rand_mat(m2);
      do_start(i, m2, AW'($urandom()), int'($urandom_range(0, 12)));
      wait_idle(i);
      if (r % 2 == 0) step(int'($urandom_range(0, 3)));
    end
    step(8);
    left = 0;
    foreach (sb[k]) if (sb[k].inst == i) left++;
    total++;
    if (left != 0) begin
      bad++;
      $display("FAIL drained inst=%0d got=%0d pending required=0", i, left);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      mon_en[i] = 1'b0;
      busy_lo[i] = 0; busy_hi[i] = -1;
      for (int a = 0; a < 1024; a++) mem[i][a] = {$urandom(), $urandom(), 32'(a)};
    end
    fork
      run_seq(0);
      run_seq(1);
      run_seq(2);
    join
    step(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vertex_fetch.md
Name: vertex_fetch

Overview:
- Front-end sequencer that drives a vertex shader's column-load and vertex-stream inputs.
- On a start pulse it latches a 4x4 fp32 transform, streams it out as four column writes, then reads count_in vertices from vertex BRAM and streams them out one per cycle.
- Sits between the scene/control logic and the vertex shader.
- Performs no arithmetic on data; pure sequencing and pipelining.

Parameters:
- ADDR_WIDTH, 10, width of the vertex BRAM address and of the vertex count.
- BRAM_LATENCY, 2, cycles from rd_en_out/addr_out to valid rdata_in; legal range 1..4.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  begin a frame; sampled only in IDLE
- mat_in  input  [3:0][3:0][31:0]  transform; mat_in[j] is column j packed {w,z,y,x}, fp32
- base_addr_in  input  ADDR_WIDTH  BRAM address of vertex 0
- count_in  input  ADDR_WIDTH  number of vertices to fetch (0 allowed)
- rd_en_out  output  1  BRAM read enable
- addr_out  output  ADDR_WIDTH  BRAM read address
- rdata_in  input  [2:0][31:0]  BRAM read data {z,y,x}
- col_set_out  output  1  column write strobe to vertex shader
- col_out  output  [3:0][31:0]  column data {w,z,y,x}
- valid_out  output  1  vertex_out valid
- vertex_out  output  [2:0][31:0]  vertex {z,y,x}
- busy_out  output  1  high in any state other than IDLE
- done_out  output  1  one-cycle pulse at frame end

Behaviour:
- States: IDLE, LOAD, FETCH, DRAIN, DONE.
- Registers: column index (2 bits), fetch counter (ADDR_WIDTH), BRAM_LATENCY-deep valid shift pipe.
- Reset: state IDLE; all outputs 0, including col_out, vertex_out and addr_out; valid pipe cleared.
  - Reset mid-frame aborts immediately; in-flight BRAM reads never produce valid_out.
  - done_out is not pulsed on abort.
- IDLE:
  - On start_in=1, latch mat_in, base_addr_in and count_in; go to LOAD.
  - start_in in any other state is ignored, and latched values are unaffected by later input changes.
- LOAD: exactly 4 cycles with col_set_out=1, presenting latched columns 0,1,2,3 in order on col_out.
  - First LOAD cycle is the cycle after start is sampled.
  - col_out holds its last value after LOAD; col_set_out=0 elsewhere.
  - Next state: FETCH if count>0, else DONE.
- FETCH: one read per cycle, with rd_en_out=1 and addr_out=(base+i) mod 2^ADDR_WIDTH for i=0..count-1.
  - Address wraps silently at 2^ADDR_WIDTH.
  - After the count-th read, go to DRAIN. rd_en_out=0 outside FETCH.
- Read pipe:
  - valid_out = rd_en_out delayed BRAM_LATENCY cycles.
  - vertex_out = rdata_in registered-through, aligned with valid_out; holds last value when valid_out=0.
  - The cycle after the last LOAD cycle issues read 0, so vertex 0 appears BRAM_LATENCY cycles later.
  - valid_out is contiguous for count cycles; no bubbles.
- DRAIN: wait until the valid pipe is empty, i.e. the final valid_out has been asserted; then go to DONE.
- DONE: done_out=1 for one cycle; next state IDLE.
  - busy_out=0 from the following cycle, and a new start_in is accepted in that same cycle.
- count_in = 2^ADDR_WIDTH-1 is the maximum. Reads never overlap column writes.

Test Plan:
- Matrix load: after reset, start_in with columns {40C00000,3F800000,40000000,41100000}, {40400000,0,41100000,40C00000}, {3F800000,40400000,3F800000,40A00000}, {3F800000,40A00000,40E00000,0} and count 0 -> col_set_out high for exactly 4 cycles starting the cycle after start, columns in that order; done_out pulses the next cycle; rd_en_out and valid_out never assert.
- Single vertex: same matrix, base 5, count 1, BRAM model returns {40800000,3F800000,40A00000} at addr 5 -> one read at addr 5 one cycle after the last col_set_out; valid_out one cycle, BRAM_LATENCY later, with that data; done_out the cycle after.
- Burst with wrap: base 1022, count 4 (ADDR_WIDTH=10), BRAM data = address -> addr_out 1022,1023,0,1 on consecutive cycles; valid_out high 4 contiguous cycles with vertex_out x-field 1022,1023,0,1.
- Start while busy: pulse start_in with different mat_in/count mid-FETCH -> ignored; original sequence completes unchanged; back-to-back start in the cycle after done_out is accepted.
- Reset mid-frame: assert rst_in one cycle after the second read issues -> next cycle all outputs 0 and state IDLE; no valid_out and no done_out afterwards.
- Latency sweep: repeat the burst with BRAM_LATENCY=1 and 4 -> valid_out offset from rd_en_out equals the parameter; count and order of vertices unchanged.
